// File: rtl/nco_voice_scheduler_if.sv
// Signal bundle between the voice scheduler and its surroundings: tick/enable control,
// FCW configuration, the shared summer link and the mixed-sample stream.
interface nco_voice_scheduler_if #(
  parameter int unsigned N_VOICES = 4,
  parameter int unsigned PHASE_W  = 24,
  parameter int unsigned SUM_W    = 20,
  parameter int unsigned MIX_W    = SUM_W + $clog2(N_VOICES),
  parameter int unsigned ADDR_W   = $clog2(N_VOICES)
);
  logic                sample_tick;
  logic [N_VOICES-1:0] voice_en;
  logic [N_VOICES-1:0] phase_clr;
  logic                cfg_we;
  logic [ADDR_W-1:0]   cfg_addr;
  logic [PHASE_W-1:0]  cfg_wdata;
  logic [PHASE_W-1:0]  acc_out;
  logic [SUM_W-1:0]    sum_in;
  logic [MIX_W-1:0]    sample_out;
  logic                sample_valid;
  logic                sample_ready;
  logic                busy;
  logic                overrun;

  // master: the scheduler itself; slave: host, summer and sample sink
  modport master (
    input  sample_tick, voice_en, phase_clr, cfg_we, cfg_addr, cfg_wdata, sum_in,
           sample_ready,
    output acc_out, sample_out, sample_valid, busy, overrun
  );

  modport slave (
    output sample_tick, voice_en, phase_clr, cfg_we, cfg_addr, cfg_wdata, sum_in,
           sample_ready,
    input  acc_out, sample_out, sample_valid, busy, overrun
  );
endinterface

// File: rtl/nco_voice_scheduler.sv
// Time-multiplexes one shared scaler/summer across N_VOICES phase accumulators and
// mixes the per-voice results into one sample delivered over valid/ready.
module nco_voice_scheduler #(
  parameter int unsigned N_VOICES = 4,
  parameter int unsigned PHASE_W  = 24,
  parameter int unsigned SUM_W    = 20,
  parameter int unsigned MIX_W    = SUM_W + $clog2(N_VOICES)
) (
  input logic                   clk,
  input logic                   rst,
  nco_voice_scheduler_if.master bus
);
  localparam int unsigned ADDR_W = $clog2(N_VOICES);
  localparam int unsigned EXT_W  = MIX_W - SUM_W;
  localparam logic [ADDR_W-1:0] LAST_V = ADDR_W'(N_VOICES - 1);

  typedef enum logic [1:0] {StIdle, StDrive, StAccum, StDone} state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   v_q;
  logic [N_VOICES-1:0] en_mask_q;
  logic [MIX_W-1:0]    mix_q;
  logic [PHASE_W-1:0]  acc_q;
  logic [MIX_W-1:0]    sample_q;
  logic                valid_q;
  logic                overrun_q;
  logic [PHASE_W-1:0]  phase_q [N_VOICES];
  logic [PHASE_W-1:0]  fcw_q   [N_VOICES];

  logic             fire;
  logic             accept;
  logic [MIX_W-1:0] sum_ext;

  assign fire    = valid_q & bus.sample_ready;
  assign accept  = bus.sample_tick & (state_q == StIdle) & (~valid_q | bus.sample_ready);
  assign sum_ext = {{EXT_W{bus.sum_in[SUM_W-1]}}, bus.sum_in};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      v_q       <= '0;
      en_mask_q <= '0;
      mix_q     <= '0;
      acc_q     <= '0;
      sample_q  <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      for (int k = 0; k < N_VOICES; k++) begin
        phase_q[k] <= '0;
        fcw_q[k]   <= '0;
      end
    end else begin
      if (fire) valid_q <= 1'b0;

      // A dropped tick in the same cycle as a cfg write still leaves overrun set.
      if (bus.cfg_we) begin
        fcw_q[bus.cfg_addr] <= bus.cfg_wdata;
        overrun_q           <= 1'b0;
      end
      if (bus.sample_tick && !accept) overrun_q <= 1'b1;

      unique case (state_q)
        StIdle: begin
          if (accept) begin
            en_mask_q <= bus.voice_en;
            mix_q     <= '0;
            v_q       <= '0;
            state_q   <= StDrive;
          end
        end
        StDrive: begin
          acc_q   <= phase_q[v_q];
          state_q <= StAccum;
        end
        StAccum: begin
          if (en_mask_q[v_q]) begin
            mix_q        <= mix_q + sum_ext;
            phase_q[v_q] <= phase_q[v_q] + fcw_q[v_q];
          end
          if (v_q == LAST_V) begin
            state_q <= StDone;
          end else begin
            v_q     <= v_q + ADDR_W'(1);
            state_q <= StDrive;
          end
        end
        StDone: begin
          sample_q <= mix_q;
          valid_q  <= 1'b1;
          state_q  <= StIdle;
        end
        default: state_q <= StIdle;
      endcase

      // Clear overrides any accumulate landing in the same cycle.
      for (int k = 0; k < N_VOICES; k++) begin
        if (bus.phase_clr[k]) phase_q[k] <= '0;
      end
    end
  end

  assign bus.acc_out      = acc_q;
  assign bus.sample_out   = sample_q;
  assign bus.sample_valid = valid_q;
  assign bus.busy         = (state_q != StIdle);
  assign bus.overrun      = overrun_q;
endmodule

// File: tb/tb_nco_voice_scheduler.sv
// Bench for nco_voice_scheduler: timing-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_nco_voice_scheduler;
  localparam int unsigned N_VOICES = 4;
  localparam int unsigned PHASE_W  = 24;
  localparam int unsigned SUM_W    = 20;
  localparam int unsigned MIX_W    = SUM_W + $clog2(N_VOICES);
  localparam int unsigned ADDR_W   = $clog2(N_VOICES);
  localparam int          SCAN     = 2 * N_VOICES;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  nco_voice_scheduler_if #(
    .N_VOICES(N_VOICES), .PHASE_W(PHASE_W), .SUM_W(SUM_W)
  ) bus ();

  nco_voice_scheduler #(
    .N_VOICES(N_VOICES), .PHASE_W(PHASE_W), .SUM_W(SUM_W), .MIX_W(MIX_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Summer stub: top byte of the phase, sign-extended.
  assign bus.sum_in = {{(SUM_W-8){bus.acc_out[PHASE_W-1]}}, bus.acc_out[PHASE_W-1 -: 8]};

  int checks   = 0;
  int failures = 0;
  logic cmp_en = 1'b0;

  task automatic do_check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint stub(input logic [PHASE_W-1:0] a);
    logic signed [7:0] b;
    b = a[PHASE_W-1 -: 8];
    return longint'(b);
  endfunction

  // Reference model: holds the outputs expected after the next rising edge.
  // A scan started in cycle s drives voice (r-1)/2 at odd r = cycle-s, accumulates it at
  // even r, and publishes the mix at r = 2*N_VOICES+1.
  int                  cyc = 0;
  int                  m_start = 0;
  int                  m_rel, m_vo;
  logic                m_active = 1'b0, m_valid = 1'b0, m_over = 1'b0;
  logic                m_fire, m_accept;
  logic [PHASE_W-1:0]  m_acc = '0;
  logic [PHASE_W-1:0]  m_phase [N_VOICES];
  logic [PHASE_W-1:0]  m_fcw   [N_VOICES];
  logic [N_VOICES-1:0] m_mask = '0;
  longint              m_mix = 0, m_out = 0;

  task automatic model_step();
    if (rst) begin
      m_active = 1'b0; m_valid = 1'b0; m_over = 1'b0; m_acc = '0;
      m_mask = '0; m_mix = 0; m_out = 0;
      for (int k = 0; k < N_VOICES; k++) begin
        m_phase[k] = '0;
        m_fcw[k]   = '0;
      end
    end else begin
      m_rel    = cyc - m_start;
      m_fire   = m_valid && bus.sample_ready;
      m_accept = bus.sample_tick && !m_active && (!m_valid || bus.sample_ready);
      if (m_fire) m_valid = 1'b0;
      if (m_active) begin
        if (m_rel <= SCAN) begin
          m_vo = (m_rel - 1) / 2;
          if (m_rel % 2 == 1) begin
            m_acc = m_phase[m_vo];
          end else if (m_mask[m_vo]) begin
            m_mix = m_mix + stub(m_acc);
            m_phase[m_vo] = m_phase[m_vo] + m_fcw[m_vo];
          end
        end else begin
          m_out    = m_mix;
          m_valid  = 1'b1;
          m_active = 1'b0;
        end
      end
      if (bus.cfg_we) begin
        m_fcw[bus.cfg_addr] = bus.cfg_wdata;
        m_over = 1'b0;
      end
      if (bus.sample_tick && !m_accept) m_over = 1'b1;
      if (m_accept) begin
        m_active = 1'b1;
        m_start  = cyc;
        m_mask   = bus.voice_en;
        m_mix    = 0;
      end
      for (int k = 0; k < N_VOICES; k++) begin
        if (bus.phase_clr[k]) m_phase[k] = '0;
      end
    end
    cyc++;
  endtask

  // Inputs change just after posedge, so this single negedge process compares first and
  // then advances the model on the stable inputs.
  always @(negedge clk) begin
    if (cmp_en) begin
      do_check("acc_out", longint'(bus.acc_out), longint'(m_acc));
      do_check("sample_valid", longint'(bus.sample_valid), longint'(m_valid));
      do_check("sample_out", longint'($signed(bus.sample_out)), m_out);
      do_check("busy", longint'(bus.busy), longint'(m_active));
      do_check("overrun", longint'(bus.overrun), longint'(m_over));
    end
    model_step();
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step();
  endtask

  task automatic set_fcw(input int addr, input logic [PHASE_W-1:0] val);
    bus.cfg_we    = 1'b1;
    bus.cfg_addr  = ADDR_W'(addr);
    bus.cfg_wdata = val;
    step();
    bus.cfg_we    = 1'b0;
  endtask

  task automatic wait_valid(inout int lat, output longint smp);
    while (!bus.sample_valid && lat < 40) begin
      step();
      lat++;
    end
    if (!bus.sample_valid) do_check("valid_timeout", 0, 1);
    smp = longint'($signed(bus.sample_out));
  endtask

  task automatic tick_wait(output int lat, output longint smp);
    bus.sample_tick = 1'b1;
    step();
    bus.sample_tick = 1'b0;
    lat = 1;
    wait_valid(lat, smp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int               lat;
    longint           smp;
    logic signed [7:0] exp8;
    longint           four_exp [4];
    four_exp[0] = 0; four_exp[1] = 10; four_exp[2] = 14; four_exp[3] = 27;

    bus.sample_tick = 1'b0; bus.voice_en = '0; bus.phase_clr = '0;
    bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_wdata = '0; bus.sample_ready = 1'b1;
    step(3);
    rst = 1'b0;
    cmp_en = 1'b1;

    // Idle after reset
    step(20);
    do_check("idle_valid", longint'(bus.sample_valid), 0);
    do_check("idle_busy", longint'(bus.busy), 0);
    do_check("idle_overrun", longint'(bus.overrun), 0);
    do_check("idle_acc_out", longint'(bus.acc_out), 0);

    // Single voice ramp, through one full phase wrap
    do_reset();
    set_fcw(0, 24'h010000);
    bus.voice_en = 4'b0001;
    for (int i = 0; i < 257; i++) begin
      tick_wait(lat, smp);
      do_check("sv_latency", longint'(lat), 10);
      exp8 = 8'(i);
      do_check("sv_sample", smp, longint'(exp8));
      if (i == 256) do_check("sv_wrap", smp, 0);
      step(6);
    end

    // Four voices, one disabled on the third tick
    do_reset();
    set_fcw(0, 24'h010000);
    set_fcw(1, 24'h020000);
    set_fcw(2, 24'h030000);
    set_fcw(3, 24'h040000);
    for (int i = 0; i < 4; i++) begin
      bus.voice_en = (i == 2) ? 4'b1011 : 4'b1111;
      tick_wait(lat, smp);
      do_check("four_sample", smp, four_exp[i]);
      step(6);
    end
    bus.voice_en = 4'b1111;

    // Backpressure and overrun
    bus.sample_ready = 1'b0;
    tick_wait(lat, smp);
    do_check("bp_sample", smp, 37);
    step(3);
    bus.sample_tick = 1'b1;
    step();
    bus.sample_tick = 1'b0;
    do_check("bp_overrun", longint'(bus.overrun), 1);
    do_check("bp_valid_held", longint'(bus.sample_valid), 1);
    do_check("bp_hold", longint'($signed(bus.sample_out)), 37);
    set_fcw(0, 24'h010000);
    do_check("bp_overrun_clr", longint'(bus.overrun), 0);
    bus.sample_ready = 1'b1;
    bus.sample_tick  = 1'b1;
    step();
    bus.sample_tick  = 1'b0;
    do_check("bp_accept_overrun", longint'(bus.overrun), 0);
    do_check("bp_accept_busy", longint'(bus.busy), 1);
    do_check("bp_accept_valid", longint'(bus.sample_valid), 0);
    lat = 1;
    wait_valid(lat, smp);
    do_check("bp_next_sample", smp, 47);
    step(6);

    // phase_clr on voice 1's accumulate, fcw[3] rewritten before voice 3 is reached
    do_reset();
    set_fcw(0, 24'h010000);
    set_fcw(1, 24'h020000);
    set_fcw(2, 24'h030000);
    set_fcw(3, 24'h040000);
    bus.sample_tick = 1'b1;
    step();
    bus.sample_tick = 1'b0;
    step();
    bus.cfg_we = 1'b1; bus.cfg_addr = 2'd3; bus.cfg_wdata = 24'h100000;
    step();
    bus.cfg_we = 1'b0;
    step();
    bus.phase_clr = 4'b0010;
    step();
    bus.phase_clr = '0;
    lat = 5;
    wait_valid(lat, smp);
    do_check("clr_scan_a", smp, 0);
    step(6);
    bus.sample_tick = 1'b1;
    step();
    bus.sample_tick = 1'b0;
    step(3);
    do_check("clr_voice1_acc", longint'(bus.acc_out), 0);
    step(4);
    do_check("cfg_voice3_acc", longint'(bus.acc_out), 24'h100000);
    lat = 8;
    wait_valid(lat, smp);
    do_check("clr_scan_b", smp, 20);
    step(6);

    // Reset during voice 2's accumulate
    bus.sample_tick = 1'b1;
    step();
    bus.sample_tick = 1'b0;
    step(5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 15; i++) begin
      do_check("rst_no_valid", longint'(bus.sample_valid), 0);
      step();
    end
    do_check("rst_busy", longint'(bus.busy), 0);
    tick_wait(lat, smp);
    do_check("rst_latency", longint'(lat), 10);
    do_check("rst_sample", smp, 0);
    step(4);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      bus.sample_tick  = ($urandom_range(0, 7) == 0);
      bus.sample_ready = ($urandom_range(0, 3) != 0);
      bus.voice_en     = N_VOICES'($urandom);
      bus.phase_clr    = ($urandom_range(0, 15) == 0) ? N_VOICES'($urandom) : '0;
      bus.cfg_we       = ($urandom_range(0, 9) == 0);
      bus.cfg_addr     = ADDR_W'($urandom);
      bus.cfg_wdata    = PHASE_W'($urandom);
      rst              = ($urandom_range(0, 499) == 0);
      step();
    end
    bus.sample_tick = 1'b0; bus.phase_clr = '0; bus.cfg_we = 1'b0; rst = 1'b0;
    bus.sample_ready = 1'b1;
    step(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/nco_voice_scheduler.md
Name: nco_voice_scheduler

Overview:
- Time-multiplexes one shared nco_scaler_summer datapath across N_VOICES polyphonic voices.
- Owns a phase accumulator and a frequency control word (FCW) per voice.
- On each sample tick, presents each voice's phase to the summer in turn, accumulates the returned sum_out values into one mixed sample, and advances the phases.
- Delivers the mixed sample downstream (DAC/PWM feeder) over a valid/ready handshake.

Parameters:
- N_VOICES, 4, number of voices; power of two, >=2
- PHASE_W, 24, phase accumulator and FCW width (matches summer accumulated_value)
- SUM_W, 20, width of summer sum_out, signed two's complement
- MIX_W, SUM_W+$clog2(N_VOICES), mixed sample width (overflow-free)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- sample_tick  in  1  one-cycle pulse requesting a new mixed sample
- voice_en  in  N_VOICES  per-voice enable, sampled when a tick is accepted
- phase_clr  in  N_VOICES  one-cycle pulse per voice, zeroes that voice's phase
- cfg_we  in  1  FCW write strobe
- cfg_addr  in  $clog2(N_VOICES)  voice index for FCW write
- cfg_wdata  in  PHASE_W  FCW value
- acc_out  out  PHASE_W  registered phase driven to summer accumulated_value
- sum_in  in  SUM_W  summer sum_out (combinational from acc_out)
- sample_out  out  MIX_W  mixed sample, signed
- sample_valid  out  1  sample_out valid
- sample_ready  in  1  downstream accepts when valid&ready
- busy  out  1  high in any state other than IDLE
- overrun  out  1  sticky: tick dropped; cleared by rst or by cfg_we

Behaviour:
- Reset values:
  - All phases, FCWs, acc_out, sample_out, and mix = 0.
  - sample_valid = 0, overrun = 0, busy = 0, state = IDLE.
  - Reset mid-scan aborts the scan; no partial sample is emitted.
- FSM states: IDLE, DRIVE, ACCUM, DONE.
- Tick acceptance: a tick is accepted only when all of the following hold:
  - state is IDLE, and
  - either sample_valid = 0, or sample_valid & sample_ready in the same cycle.
- On acceptance:
  - latch voice_en into en_mask;
  - mix <= 0, v <= 0;
  - go to DRIVE.
- Any tick not accepted sets overrun and is discarded; no queuing.
- DRIVE:
  - acc_out <= phase[v];
  - go to ACCUM.
- ACCUM (acc_out is stable, sum_in is valid):
  - mix <= mix + (en_mask[v] ? sign_extend(sum_in) : 0);
  - if en_mask[v], phase[v] <= phase[v] + fcw[v], wrapping mod 2^PHASE_W;
  - if v == N_VOICES-1, go to DONE; else v++ and go to DRIVE.
- DONE:
  - sample_out <= mix;
  - sample_valid <= 1;
  - go to IDLE.
- Latency: for a tick accepted in cycle t, sample_valid is first high at cycle t+2*N_VOICES+2 (t+10 for N_VOICES=4). Latency is fixed; disabled voices still take 2 cycles each.
- Output handshake:
  - sample_valid and sample_out hold until valid & ready.
  - sample_valid then clears the next cycle, unless DONE reloads it in that same cycle.
- Disabled voice:
  - contributes 0 to mix;
  - its phase holds;
  - acc_out is still driven with its phase.
- phase_clr[k]:
  - phase[k] <= 0 in the next cycle, in any state.
  - If it coincides with that voice's ACCUM update, clear wins (phase = 0, not 0+fcw).
  - mix still uses the sum_in already presented.
- cfg write:
  - fcw[cfg_addr] <= cfg_wdata next cycle;
  - also clears overrun.
  - A write during a scan takes effect at that voice's ACCUM if that ACCUM has not yet occurred; otherwise it applies from the next scan.
  - If a write and an ACCUM for the same voice occur in the same cycle, the ACCUM uses the old fcw.
- Arithmetic: sum_in is sign-extended to MIX_W; with MIX_W as defaulted, no saturation is needed.

Test Plan:
- Bench stub: sum_in = sign_extend(acc_out[PHASE_W-1:PHASE_W-8]).
- Reset, then idle 20 cycles -> sample_valid=0, busy=0, overrun=0, acc_out=0.
- Single voice:
  - Stimulus: fcw[0]=0x010000, voice_en=4'b0001, sample_ready=1, tick every 16 cycles.
  - Required: samples 0,1,2,…; sample_valid asserted exactly 10 cycles after each tick.
  - After 256 ticks the phase wraps, so the next sample = 0.
- Four voices:
  - Stimulus: fcw = {0x010000, 0x020000, 0x030000, 0x040000}, all enabled.
  - Required: 2nd sample = 10 (stub values 0+0+0+0, then 1+2+3+4).
  - Also: a voice disabled at tick time contributes 0 and its phase holds.
- Backpressure / overrun:
  - Stimulus: sample_ready=0, tick, then a 2nd tick after DONE.
  - Required: overrun=1, sample_out unchanged and held valid.
  - Then cfg_we -> overrun=0; ready=1 together with a tick in the same cycle -> accepted, no overrun.
- phase_clr:
  - Pulse phase_clr[1] coincident with voice 1's ACCUM -> next scan presents acc_out=0 for voice 1.
  - Separately, cfg write to fcw[3] mid-scan before v=3 -> new FCW applied in this scan.
- Reset asserted in the ACCUM of voice 2 -> all phases=0, sample_valid stays 0, next tick produces sample 0.
